// File: rtl/eca_outbuf_drain_if.sv
// Output-buffer read port plus parity-packet valid/ready stream for eca_outbuf_drain.
// master = the drain block, slave = output buffer + packet consumer.
interface eca_outbuf_drain_if #(
  parameter int DATA_W = 32,
  parameter int PKT_W  = 8,
  parameter int IDX_W  = 2
);
  logic              outbuf_empty;
  logic              outbuf_rd_req;
  logic              outbuf_rd_data_val;
  logic [DATA_W-1:0] outbuf_rd_data;
  logic              pkt_valid;
  logic              pkt_ready;
  logic [PKT_W-1:0]  pkt_data;
  logic [IDX_W-1:0]  pkt_idx;
  logic              pkt_last;

  modport master (
    input  outbuf_empty, outbuf_rd_data_val, outbuf_rd_data, pkt_ready,
    output outbuf_rd_req, pkt_valid, pkt_data, pkt_idx, pkt_last
  );

  modport slave (
    output outbuf_empty, outbuf_rd_data_val, outbuf_rd_data, pkt_ready,
    input  outbuf_rd_req, pkt_valid, pkt_data, pkt_idx, pkt_last
  );
endinterface

// File: rtl/eca_outbuf_drain.sv
// Pulls parity words from the engine output buffer into a credit-controlled FIFO and
// serializes each into m_eff packets. Optional word counter: ECA_OUTBUF_DRAIN_STATS_EN.
module eca_outbuf_drain #(
  parameter int K_MAX         = 4,
  parameter int W             = 4,
  parameter int PACKET_LENGTH = 2,
  parameter int M_MAX         = 4,
  parameter int FIFO_DEPTH    = 4,
  parameter int DATA_W        = W * PACKET_LENGTH * K_MAX,
  parameter int PKT_W         = W * PACKET_LENGTH
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       drain_en_i,
  input  logic [$clog2(M_MAX)-1:0]   m_val_i,
  eca_outbuf_drain_if.master         bus,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       err_unexp_val_o,
  output logic [15:0]                word_cnt_o
);
  localparam int IDX_W = $clog2(M_MAX);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [IDX_W:0] M_MAX_C = (IDX_W + 1)'(M_MAX);
  localparam logic [IDX_W:0] M_ONE   = (IDX_W + 1)'(1);
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e             state_q, state_d;
  logic [IDX_W:0]     m_eff_q, m_eff_d;
  logic               rd_req_q, rd_req_d;
  logic               outstanding_q, outstanding_d;
  logic               err_q, err_d;
  logic               done_q, done_d;
  logic               rst_hold_q;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0]  mem_q [FIFO_DEPTH];

  logic              accept, val_seen, push_req, push, pop, fire, last_beat;
  logic              fifo_full, fifo_nempty, overflow, unexp, credit_ok;
  logic [DATA_W-1:0] head;

  // A request only counts as accepted when the buffer actually had a word; this
  // keeps the one-cycle-late empty flag from creating phantom outstanding reads.
  assign accept      = rd_req_q & ~bus.outbuf_empty;
  assign val_seen    = bus.outbuf_rd_data_val & ~rst_hold_q;
  assign push_req    = val_seen & outstanding_q;
  assign unexp       = val_seen & ~outstanding_q;
  assign fifo_full   = (count_q == CNT_W'(FIFO_DEPTH));
  assign fifo_nempty = (count_q != '0);
  assign last_beat   = ({1'b0, idx_q} == (m_eff_q - M_ONE));
  assign fire        = fifo_nempty & bus.pkt_ready;
  assign pop         = fire & last_beat;
  assign push        = push_req & (~fifo_full | pop);
  assign overflow    = push_req & fifo_full & ~pop;
  assign head        = mem_q[rd_ptr_q];

  always_comb begin
    // NOTE: every signal gets a default before any branch so no path infers a latch.
    state_d       = state_q;
    m_eff_d       = m_eff_q;
    done_d        = 1'b0;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    idx_d         = idx_q;
    count_d       = count_q + CNT_W'(push) - CNT_W'(pop);
    outstanding_d = accept | (outstanding_q & ~push_req);
    err_d         = err_q | unexp | overflow;

    unique case (state_q)
      IDLE: begin
        if (drain_en_i) begin
          state_d = RUN;
          m_eff_d = (m_val_i == '0) ? M_MAX_C : {1'b0, m_val_i};
        end
      end
      RUN: begin
        if (!drain_en_i) state_d = DRAIN;
      end
      DRAIN: begin
        if (drain_en_i) begin
          state_d = RUN;
        end else if (!fifo_nempty && !outstanding_q && !rd_req_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (fire) idx_d = last_beat ? '0 : idx_q + IDX_W'(1);

    // Credit looks at next-cycle occupancy, which already includes the request now on the bus.
    credit_ok = ({1'b0, count_d} + (CNT_W + 1)'(outstanding_d)) < DEPTH_C;
    rd_req_d  = (state_d == RUN) && !bus.outbuf_empty && credit_ok;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= IDLE;
      m_eff_q       <= '0;
      rd_req_q      <= 1'b0;
      outstanding_q <= 1'b0;
      err_q         <= 1'b0;
      done_q        <= 1'b0;
      rst_hold_q    <= 1'b1;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      idx_q         <= '0;
    end else begin
      // NOTE: registers use non-blocking assignment so each one samples pre-edge values.
      state_q       <= state_d;
      m_eff_q       <= m_eff_d;
      rd_req_q      <= rd_req_d;
      outstanding_q <= outstanding_d;
      err_q         <= err_d;
      done_q        <= done_d;
      rst_hold_q    <= 1'b0;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      idx_q         <= idx_d;
    end
  end

  // NOTE: FIFO storage has no reset; count gates every read and outputs are masked while empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.outbuf_rd_data;
  end

  assign bus.outbuf_rd_req = rd_req_q;
  assign bus.pkt_valid     = fifo_nempty;
  assign bus.pkt_data      = fifo_nempty ? head[int'(idx_q) * PKT_W +: PKT_W] : '0;
  assign bus.pkt_idx       = fifo_nempty ? idx_q : '0;
  assign bus.pkt_last      = fifo_nempty & last_beat;
  assign busy_o            = (state_q != IDLE);
  assign done_o            = done_q;
  assign err_unexp_val_o   = err_q;

`ifdef ECA_OUTBUF_DRAIN_STATS_EN
  logic [15:0] word_cnt_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      word_cnt_q <= '0;
    end else if (state_q == IDLE && state_d == RUN) begin
      word_cnt_q <= '0;
    end else if (state_q != IDLE && pop && word_cnt_q != 16'hFFFF) begin
      word_cnt_q <= word_cnt_q + 16'd1;
    end
  end

  assign word_cnt_o = word_cnt_q;
`else
  assign word_cnt_o = '0;
`endif
endmodule

// File: tb/tb_eca_outbuf_drain.sv
// Scoreboard bench for eca_outbuf_drain: a bus model of the output buffer pushes the
// expected packets of every word it hands out; a monitor collects emitted packets.
module tb_eca_outbuf_drain;
  localparam int DATA_W     = 32;
  localparam int PKT_W      = 8;
  localparam int IDX_W      = 2;
  localparam int M_MAX      = 4;
  localparam int FIFO_DEPTH = 4;

  typedef struct packed {
    logic [PKT_W-1:0] data;
    logic [IDX_W-1:0] idx;
    logic             last;
  } pkt_t;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             drain_en = 1'b0;
  logic             pkt_ready = 1'b0;
  logic             inj_val = 1'b0;
  logic [IDX_W-1:0] m_val = '0;
  logic             busy, done, err;
  logic [15:0]      word_cnt;

  logic              mdl_val = 1'b0, mdl_empty = 1'b1, nxt_val = 1'b0;
  logic [DATA_W-1:0] mdl_data = '0, nxt_data = '0;
  logic [DATA_W-1:0] ob_q[$];
  pkt_t              exp_q[$], obs_q[$];

  int n_cmp = 0, n_err = 0, m_cur = 1;
  int req_cnt = 0, done_cnt = 0, done_busy_cnt = 0;
  int cyc = 0, first_req = -1, first_val = -1;

  eca_outbuf_drain_if #(.DATA_W(DATA_W), .PKT_W(PKT_W), .IDX_W(IDX_W)) bus_if ();

  assign bus_if.outbuf_empty       = mdl_empty;
  assign bus_if.outbuf_rd_data_val = mdl_val | inj_val;
  assign bus_if.outbuf_rd_data     = mdl_data;
  assign bus_if.pkt_ready          = pkt_ready;

  eca_outbuf_drain #(
    .K_MAX(4), .W(4), .PACKET_LENGTH(2), .M_MAX(M_MAX), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rstn(rstn), .drain_en_i(drain_en), .m_val_i(m_val), .bus(bus_if.master),
    .busy_o(busy), .done_o(done), .err_unexp_val_o(err), .word_cnt_o(word_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Output buffer: a request seen while the buffer shows a word hands that word out,
  // and the expected packets of that word enter the scoreboard.
  always @(negedge clk) begin : ob_model
    pkt_t p;
    nxt_val = 1'b0;
    if (rstn && bus_if.outbuf_rd_req) begin
      req_cnt++;
      if (!mdl_empty && ob_q.size() > 0) begin
        nxt_data = ob_q.pop_front();
        nxt_val  = 1'b1;
        for (int i = 0; i < m_cur; i++) begin
          p.data = nxt_data[i*PKT_W +: PKT_W];
          p.idx  = IDX_W'(i);
          p.last = (i == m_cur - 1);
          exp_q.push_back(p);
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    mdl_val   = nxt_val;
    mdl_data  = nxt_val ? nxt_data : '0;
    mdl_empty = (ob_q.size() == 0);
  end

  always @(negedge clk) begin : monitor
    pkt_t p;
    if (rstn) begin
      if (bus_if.pkt_valid && pkt_ready) begin
        p.data = bus_if.pkt_data;
        p.idx  = bus_if.pkt_idx;
        p.last = bus_if.pkt_last;
        obs_q.push_back(p);
      end
      if (bus_if.outbuf_rd_req && first_req < 0) first_req = cyc;
      if (bus_if.pkt_valid && first_val < 0) first_val = cyc;
      if (done) begin
        done_cnt++;
        if (busy) done_busy_cnt++;
      end
    end
  end

  task automatic do_reset();
    rstn = 1'b0;
    drain_en = 1'b0;
    pkt_ready = 1'b0;
    inj_val = 1'b0;
    ob_q.delete();
    exp_q.delete();
    obs_q.delete();
    req_cnt = 0; done_cnt = 0; done_busy_cnt = 0; first_req = -1; first_val = -1;
    repeat (2) @(posedge clk);
    #1;
    mdl_empty = 1'b1;
    rstn = 1'b1;
  endtask

  task automatic wait_pkts(input int n, input int budget);
    int c = 0;
    while (obs_q.size() < n && c < budget) begin
      @(posedge clk);
      c++;
    end
    @(posedge clk);
    #2;
  endtask

  task automatic wait_done(input int budget);
    int c = 0;
    while (done_cnt == 0 && c < budget) begin
      @(posedge clk);
      c++;
    end
    repeat (4) @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    inj_val = 1'b1;
    @(posedge clk);
    #1;
    inj_val = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    n_cmp++;
    if (err !== 1'b0) begin
      n_err++; $display("FAIL reset_val_ignore: err=%b want 0", err);
    end
    n_cmp++;
    if ({bus_if.pkt_valid, bus_if.pkt_last, bus_if.outbuf_rd_req, busy, done} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: valid/last/req/busy/done=%b want 00000",
               {bus_if.pkt_valid, bus_if.pkt_last, bus_if.outbuf_rd_req, busy, done});
    end
    n_cmp++;
    if (bus_if.pkt_data !== '0 || bus_if.pkt_idx !== '0 || word_cnt !== 16'd0) begin
      n_err++;
      $display("FAIL reset_data: data=%h idx=%0d word_cnt=%0d want 0/0/0",
               bus_if.pkt_data, bus_if.pkt_idx, word_cnt);
    end
  endtask

  task automatic test_basic_m2();
    logic [PKT_W-1:0] lit [6] = '{8'h00, 8'h00, 8'hFF, 8'hFF, 8'h81, 8'h11};
    pkt_t o, e;
    int exp_wc;
    do_reset();
    m_val = 2'd2; m_cur = 2;
    ob_q.push_back(32'h0000_0000);
    ob_q.push_back(32'hFFFF_FFFF);
    ob_q.push_back(32'hF1A2_1181);
    pkt_ready = 1'b1;
    drain_en = 1'b1;
    wait_pkts(6, 60);
    n_cmp++;
    if (obs_q.size() != 6) begin
      n_err++; $display("FAIL m2_count: got %0d packets want 6", obs_q.size());
    end
    for (int i = 0; i < 6 && obs_q.size() > 0 && exp_q.size() > 0; i++) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      n_cmp++;
      if (o !== e || o.data !== lit[i] || o.idx !== IDX_W'(i % 2) || o.last !== (i % 2 == 1)) begin
        n_err++;
        $display("FAIL m2_pkt%0d: got data=%h idx=%0d last=%b want data=%h idx=%0d last=%b",
                 i, o.data, o.idx, o.last, lit[i], i % 2, (i % 2 == 1));
      end
    end
`ifdef ECA_OUTBUF_DRAIN_STATS_EN
    exp_wc = 3;
`else
    exp_wc = 0;
`endif
    n_cmp++;
    if (word_cnt !== 16'(exp_wc)) begin
      n_err++; $display("FAIL m2_word_cnt: got %0d want %0d", word_cnt, exp_wc);
    end
    drain_en = 1'b0;
    wait_done(20);
    n_cmp++;
    if (done_cnt != 1 || busy !== 1'b0) begin
      n_err++; $display("FAIL m2_done: done pulses=%0d busy=%b want 1/0", done_cnt, busy);
    end
  endtask

  task automatic test_m_max();
    logic [PKT_W-1:0] lit [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    pkt_t o, e;
    do_reset();
    m_val = 2'd0; m_cur = M_MAX;
    ob_q.push_back(32'h4433_2211);
    pkt_ready = 1'b1;
    drain_en = 1'b1;
    wait_pkts(4, 40);
    n_cmp++;
    if (obs_q.size() != 4) begin
      n_err++; $display("FAIL m4_count: got %0d packets want 4", obs_q.size());
    end
    for (int i = 0; i < 4 && obs_q.size() > 0 && exp_q.size() > 0; i++) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      n_cmp++;
      if (o !== e || o.data !== lit[i] || o.idx !== IDX_W'(i) || o.last !== (i == 3)) begin
        n_err++;
        $display("FAIL m4_pkt%0d: got data=%h idx=%0d last=%b want data=%h idx=%0d last=%b",
                 i, o.data, o.idx, o.last, lit[i], i, (i == 3));
      end
    end
    n_cmp++;
    if (first_val - first_req != 2) begin
      n_err++; $display("FAIL m4_latency: req->valid %0d cycles want 2", first_val - first_req);
    end
  endtask

  task automatic test_backpressure();
    pkt_t first, cur, o, e;
    logic got = 1'b0;
    int unstable = 0;
    do_reset();
    m_val = 2'd3; m_cur = 3;
    for (int i = 0; i < 6; i++) ob_q.push_back(32'hC0DE_0000 + 32'(i * 32'h0101_0101));
    drain_en = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (bus_if.pkt_valid) begin
        cur.data = bus_if.pkt_data; cur.idx = bus_if.pkt_idx; cur.last = bus_if.pkt_last;
        if (!got) begin
          first = cur; got = 1'b1;
        end else if (cur !== first) begin
          unstable++;
        end
      end
    end
    @(posedge clk);
    #2;
    n_cmp++;
    if (req_cnt != FIFO_DEPTH || bus_if.outbuf_rd_req !== 1'b0) begin
      n_err++;
      $display("FAIL stall_reads: reads=%0d req=%b want %0d/0", req_cnt, bus_if.outbuf_rd_req, FIFO_DEPTH);
    end
    n_cmp++;
    if (!got || unstable != 0) begin
      n_err++; $display("FAIL stall_stable: valid_seen=%b unstable_cycles=%0d want 1/0", got, unstable);
    end
    pkt_ready = 1'b1;
    wait_pkts(18, 120);
    n_cmp++;
    if (obs_q.size() != 18 || exp_q.size() != 18) begin
      n_err++;
      $display("FAIL stall_count: got %0d packets (expected queue %0d) want 18", obs_q.size(), exp_q.size());
    end
    for (int i = 0; obs_q.size() > 0 && exp_q.size() > 0; i++) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL stall_pkt%0d: got data=%h idx=%0d last=%b want data=%h idx=%0d last=%b",
                 i, o.data, o.idx, o.last, e.data, e.idx, e.last);
      end
    end
  endtask

  task automatic test_drain();
    pkt_t o, e;
    int seen = 0, c = 0;
    do_reset();
    m_val = 2'd1; m_cur = 1;
    for (int i = 0; i < 6; i++) ob_q.push_back(32'h0000_0010 + 32'(i));
    drain_en = 1'b1;
    while (seen < 3 && c < 30) begin
      @(posedge clk);
      #1;
      if (bus_if.outbuf_rd_req) seen++;
      c++;
    end
    drain_en = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    n_cmp++;
    if (busy !== 1'b1 || done_cnt != 0) begin
      n_err++; $display("FAIL drain_hold: busy=%b done pulses=%0d want 1/0", busy, done_cnt);
    end
    pkt_ready = 1'b1;
    wait_done(40);
    n_cmp++;
    if (req_cnt != 3) begin
      n_err++; $display("FAIL drain_reads: reads=%0d want 3", req_cnt);
    end
    n_cmp++;
    if (done_cnt != 1 || done_busy_cnt != 0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL drain_done: pulses=%0d done_with_busy=%0d busy=%b want 1/0/0",
               done_cnt, done_busy_cnt, busy);
    end
    n_cmp++;
    if (obs_q.size() != 3 || exp_q.size() != 3) begin
      n_err++; $display("FAIL drain_count: got %0d packets (expected queue %0d) want 3", obs_q.size(), exp_q.size());
    end
    for (int i = 0; obs_q.size() > 0 && exp_q.size() > 0; i++) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      n_cmp++;
      if (o !== e || o.last !== 1'b1) begin
        n_err++;
        $display("FAIL drain_pkt%0d: got data=%h idx=%0d last=%b want data=%h idx=%0d last=1",
                 i, o.data, o.idx, o.last, e.data, e.idx);
      end
    end
  endtask

  task automatic test_err_unexp();
    do_reset();
    m_cur = 1;
    @(posedge clk);
    #1;
    inj_val = 1'b1;
    @(posedge clk);
    #1;
    inj_val = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    n_cmp++;
    if (err !== 1'b1 || bus_if.pkt_valid !== 1'b0 || obs_q.size() != 0) begin
      n_err++;
      $display("FAIL err_set: err=%b valid=%b packets=%0d want 1/0/0", err, bus_if.pkt_valid, obs_q.size());
    end
    m_val = 2'd1;
    ob_q.push_back(32'h0000_005A);
    pkt_ready = 1'b1;
    drain_en = 1'b1;
    wait_pkts(1, 30);
    n_cmp++;
    if (err !== 1'b1 || obs_q.size() != 1) begin
      n_err++; $display("FAIL err_sticky: err=%b packets=%0d want 1/1", err, obs_q.size());
    end
    do_reset();
    @(posedge clk);
    #2;
    n_cmp++;
    if (err !== 1'b0) begin
      n_err++; $display("FAIL err_clear: err=%b want 0", err);
    end
  endtask

  task automatic test_reset_mid();
    pkt_t o, e;
    int c = 0;
    do_reset();
    m_val = 2'd2; m_cur = 2;
    ob_q.push_back(32'h0BAD_F00D);
    ob_q.push_back(32'h1234_5678);
    drain_en = 1'b1;
    while (!bus_if.pkt_valid && c < 20) begin
      @(posedge clk);
      #1;
      c++;
    end
    pkt_ready = 1'b1;
    @(posedge clk);
    #1;
    pkt_ready = 1'b0;
    #1;
    n_cmp++;
    if (bus_if.pkt_valid !== 1'b1 || bus_if.pkt_idx !== 2'd1) begin
      n_err++; $display("FAIL mid_setup: valid=%b idx=%0d want 1/1", bus_if.pkt_valid, bus_if.pkt_idx);
    end
    rstn = 1'b0;
    #1;
    n_cmp++;
    if ({bus_if.pkt_valid, bus_if.pkt_last, bus_if.outbuf_rd_req, busy, done, err} !== 6'b0 ||
        bus_if.pkt_data !== '0 || bus_if.pkt_idx !== '0) begin
      n_err++;
      $display("FAIL mid_reset_out: valid/last/req/busy/done/err=%b data=%h idx=%0d want all 0",
               {bus_if.pkt_valid, bus_if.pkt_last, bus_if.outbuf_rd_req, busy, done, err},
               bus_if.pkt_data, bus_if.pkt_idx);
    end
    ob_q.delete();
    exp_q.delete();
    obs_q.delete();
    ob_q.push_back(32'hA5C3_7E18);
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    pkt_ready = 1'b1;
    wait_pkts(2, 30);
    n_cmp++;
    if (obs_q.size() != 2) begin
      n_err++; $display("FAIL mid_count: got %0d packets want 2", obs_q.size());
    end
    if (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      n_cmp++;
      if (o !== e || o.data !== 8'h18 || o.idx !== 2'd0) begin
        n_err++;
        $display("FAIL mid_first_pkt: got data=%h idx=%0d last=%b want data=18 idx=0 last=0",
                 o.data, o.idx, o.last);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_m2();
    test_m_max();
    test_backpressure();
    test_drain();
    test_err_unexp();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before the summary");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/eca_outbuf_drain.md
Name: eca_outbuf_drain

Overview:
Downstream stage of eca_top. Pulls parity words from the engine output buffer through the outbuf_rd_req / outbuf_rd_data_val interface. Holds them in a small credit-controlled FIFO and serializes each word into m parity packets of W*PACKET_LENGTH bits on a valid/ready stream toward the host/DMA side.

Parameters:
K_MAX, 4, max data packets per stripe (sets word width)
W, 4, Galois field word width in bits
PACKET_LENGTH, 2, field words per packet
M_MAX, 4, max parity packets per word; must be a power of 2
DATA_W, W*PACKET_LENGTH*K_MAX, outbuf word width (32)
PKT_W, W*PACKET_LENGTH, output packet width (8)
FIFO_DEPTH, 4, word FIFO entries; power of 2, >= 2

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
drain_en  in  1  level; 1 = run, 0 = finish buffered words and stop
m_val  in  $clog2(M_MAX)  parity packets per word; 0 encodes M_MAX; sampled on IDLE->RUN only
outbuf_empty  in  1  engine output buffer holds no word
outbuf_rd_req  out  1  read request to output buffer
outbuf_rd_data_val  in  1  read data valid, exactly 1 cycle after an accepted req
outbuf_rd_data  in  DATA_W  parity word; packet i at [i*PKT_W +: PKT_W]
pkt_valid  out  1  output packet valid
pkt_ready  in  1  consumer ready
pkt_data  out  PKT_W  parity packet
pkt_idx  out  $clog2(M_MAX)  parity index of pkt_data, 0..m-1
pkt_last  out  1  last packet of the current word
busy  out  1  state != IDLE
done  out  1  one-cycle pulse on DRAIN->IDLE
err_unexp_val  out  1  sticky: rd_data_val seen with no outstanding request
word_cnt  out  16  words fully emitted (see Optional Feature)

Behaviour:
- Reset (async, rstn=0): state IDLE. All outputs 0. FIFO empty, credits cleared, err cleared, counters 0. Reset mid-transfer discards all buffered and in-flight data. An rd_data_val arriving the cycle after reset release is ignored and does not set err.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE->RUN when drain_en=1. Latches m_eff = (m_val==0) ? M_MAX : m_val.
  - RUN->DRAIN when drain_en=0.
  - DRAIN->IDLE when FIFO empty, no read outstanding and no packet pending. done=1 for 1 cycle.
  - DRAIN->RUN if drain_en returns to 1 before completion; m_eff is not re-latched.
- Read issue: outbuf_rd_req=1 (registered) only in RUN when all of the following hold:
  - !outbuf_empty
  - fifo_count + outstanding < FIFO_DEPTH
- outstanding is 0 or 1. A request is accepted in the cycle it is asserted. Max one request per cycle; back-to-back requests are allowed while credit remains.
- Data capture: rd_data_val with outstanding=1 writes outbuf_rd_data into the FIFO and clears outstanding. Same-cycle new request plus val is legal; net outstanding stays 1. rd_data_val with outstanding=0 sets err_unexp_val and the data is dropped.
- Serializer: the head word is emitted as packets idx 0..m_eff-1.
  - pkt_data = head[idx*PKT_W +: PKT_W]; pkt_last = (idx == m_eff-1).
  - A transfer occurs on pkt_valid & pkt_ready. The idx counter advances on each transfer. On the last transfer the FIFO pops and idx wraps to 0.
  - pkt_valid=1 whenever the FIFO is non-empty; pkt_data/idx/last stay stable while valid & !ready.
  - With m_eff=1 every packet has pkt_last=1.
  - Throughput: 1 packet/cycle with ready held high. First packet appears 2 cycles after outbuf_rd_req (req, val, FIFO registered output).
- FIFO: simultaneous push and pop with the FIFO full is legal and keeps the count. The credit rule guarantees no push occurs into a full FIFO without a pop; an overflow asserts err_unexp_val.
- FIFO pointers wrap modulo FIFO_DEPTH; count width is $clog2(FIFO_DEPTH)+1.

Optional Feature:
Macro ECA_OUTBUF_DRAIN_STATS_EN.
- Defined: word_cnt increments on each pkt_last transfer. It saturates at 16'hFFFF, clears on reset and on IDLE->RUN, and holds in IDLE.
- Undefined: word_cnt is tied to 0 and no counter logic is instantiated.

Test Plan:
- m_val=2, 3 words 0x00000000/0xFFFFFFFF/0xF1A2_1181 queued, pkt_ready=1 -> 6 packets: 00,00,FF,FF,81,11. idx sequence 0,1,0,1,0,1; pkt_last on every odd beat; word_cnt=3 if stats enabled.
- m_val=0 (M_MAX=4), word 0x44332211 -> packets 11,22,33,44 with idx 0..3 and pkt_last only on 44.
- pkt_ready=0 for 20 cycles, outbuf non-empty -> exactly FIFO_DEPTH=4 reads issued then rd_req stays 0. pkt_data is stable; after ready=1 all 4 words emit with no loss.
- drain_en dropped with 2 words in FIFO and 1 outstanding -> no new rd_req; 3 words (3*m packets) emitted; done pulses once and busy falls in the same cycle.
- rd_data_val pulsed with no request -> err_unexp_val=1 and sticky, no packet emitted; cleared only by rstn.
- rstn asserted mid-word (idx=1) -> all outputs 0 immediately. After release with drain_en=1, the first packet emitted is idx 0 of a newly read word.
